rom_fetch_buf: RTL and testbench
================================

# rom_fetch_buf

Read-fetch stage directly downstream of the address generator. It takes the generator's address stream and issues reads to a synchronous ROM/scratchpad with 1-cycle read latency. Returned words are buffered in a small show-ahead FIFO and presented to the PE-side consumer with a valid/ready handshake. Credit-based flow control back-pressures the address generator so no returned word is ever dropped.

## Interface
- ADDR_WIDTH, 8, address width, matches the generator.
- DATA_WIDTH, 16, memory word width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous clear of buffered and in-flight data.
- addr_in  in  ADDR_WIDTH  read address from the generator.
- addr_valid  in  1  addr_in valid (the generator's ADD_VALID).
- addr_last  in  1  addr_in is the last address of the series.
- addr_ready  out  1  fetch can accept an address this cycle.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_rdata  in  DATA_WIDTH  read data; valid the cycle after mem_rd_en.
- dout  out  DATA_WIDTH  FIFO head word.
- dout_last  out  1  head word is the last of the series.
- dout_valid  out  1  head word valid.
- dout_ready  in  1  consumer accepts the head word.
- occupancy  out  clog2(DEPTH)+1  number of stored entries.

## Operation
- Registered state:
  - FIFO storage of {data, last}.
  - wptr, rptr: clog2(DEPTH) bits each, wrap naturally.
  - count: 0..DEPTH.
  - rd_pend: 1-bit read-in-flight flag.
  - last_pend: last flag of the in-flight read.
- credits = DEPTH - count - rd_pend. This is conservative: a pop in the same cycle is not credited.
- addr_ready = (credits != 0) & ~flush. Combinational from registers and flush only; it never depends on addr_valid.
- Accept is addr_valid & addr_ready.
  - mem_rd_en = accept.
  - mem_addr = addr_in (combinational pass-through).
  - rd_pend <= accept; last_pend <= addr_last.
- Write: when rd_pend is 1, {mem_rdata, last_pend} is written at wptr and wptr increments. Credits guarantee the FIFO is never full at write time.
- Pop: dout_valid & dout_ready advances rptr.
- dout = data[rptr], dout_last = last[rptr], dout_valid = (count != 0), occupancy = count.
- Simultaneous write and pop leaves count unchanged. Pop when empty is impossible, because dout_valid is 0.
- Flush, for one cycle:
  - count, wptr, rptr and rd_pend all go to 0.
  - Any mem_rdata returning in the next cycle is discarded.
  - addr_ready is 0 during the flush cycle.
  - flush takes priority over a simultaneous write or pop.
- Reset (rst=0) has the same effect as flush, plus last_pend=0. Reset mid-burst discards everything. Nothing is emitted until new addresses are accepted after rst returns to 1.

## Timing
- Reset values:
  - addr_ready=0 while rst=0.
  - mem_rd_en=0, dout_valid=0, dout_last=0, occupancy=0.
  - dout is don't-care.
- Latency: address accepted in cycle N, mem_rdata valid in N+1, word written at the end of N+1, dout_valid=1 in cycle N+2. Two cycles total.
- Throughput: 1 word per cycle sustained while dout_ready=1 (steady state count≤1, rd_pend=1, credits≥2).
- With dout_ready=0: exactly DEPTH addresses are accepted, then addr_ready=0. It stays 0 until the cycle after the first pop.
- mem_addr and mem_rd_en are combinational outputs. The memory samples them at the same edge the accept occurs.

## Test plan
- Single read: reset, then addr_in=0x05 with addr_last=1 for one cycle, mem returns 0x1234. Required: dout=0x1234, dout_last=1, dout_valid=1 exactly 2 cycles after accept; occupancy 1, then 0 after the pop.
- Burst: addresses 0..7 back-to-back with dout_ready=1, mem returns addr*3. Required: 8 consecutive dout beats 0,3,…,21 starting 2 cycles after the first accept; addr_ready never drops; only beat 8 has dout_last=1.
- Back-pressure: DEPTH=4, dout_ready=0, addr_valid held for addresses 0..9. Required: 4 accepts, then addr_ready=0 with occupancy=4. After raising dout_ready, all 10 words arrive in order with no loss or duplication.
- Flush mid-stream: 3 words buffered, one read in flight, assert flush for 1 cycle. Required: next cycle occupancy=0 and dout_valid=0; the in-flight word never appears; addr_ready=1 the cycle after flush.
- Reset mid-operation: rst=0 for 1 cycle with 2 words buffered. Required: all outputs at reset values; a subsequent single read behaves as in the first scenario.
- Wrap-around: 3×DEPTH words with random dout_ready (50%). Required: in-order data and last flags; occupancy never exceeds DEPTH; mem_rd_en never asserted while credits=0.

Source files
------------

// File: rtl/rom_fetch_buf_if.sv
// rom_fetch_buf_if: bundles the address, memory and consumer-side signals of rom_fetch_buf.
//   slave  modport: the fetch buffer itself.
//   master modport: the surrounding environment (address generator, ROM, consumer).
//   flush          : synchronous clear of buffered and in-flight data.
//   addr_*         : address stream from the generator (valid/ready, plus series-last flag).
//   mem_*          : read port of a synchronous memory with 1-cycle read latency.
//   dout_*         : FIFO head presented to the consumer (valid/ready).
//   occupancy      : number of stored entries.
interface rom_fetch_buf_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
);
  logic                       flush;
  logic [ADDR_WIDTH-1:0]      addr_in;
  logic                       addr_valid;
  logic                       addr_last;
  logic                       addr_ready;
  logic                       mem_rd_en;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_rdata;
  logic [DATA_WIDTH-1:0]      dout;
  logic                       dout_last;
  logic                       dout_valid;
  logic                       dout_ready;
  logic [$clog2(DEPTH):0]     occupancy;

  modport slave (
    input  flush, addr_in, addr_valid, addr_last, mem_rdata, dout_ready,
    output addr_ready, mem_rd_en, mem_addr, dout, dout_last, dout_valid, occupancy
  );

  modport master (
    output flush, addr_in, addr_valid, addr_last, mem_rdata, dout_ready,
    input  addr_ready, mem_rd_en, mem_addr, dout, dout_last, dout_valid, occupancy
  );
endinterface

// File: rtl/rom_fetch_buf.sv
// rom_fetch_buf: read-fetch stage between an address generator and a PE-side consumer.
// Accepted addresses are issued straight to a 1-cycle-latency memory; returned words land in a
// show-ahead FIFO. Credits (free entries minus the read in flight) gate addr_ready so a
// returned word always has a slot.
// Ports:
//   clk  : rising-edge clock.
//   rst  : synchronous active-low reset.
//   bus  : rom_fetch_buf_if.slave (flush, addr_*, mem_*, dout_*, occupancy).
module rom_fetch_buf #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input logic            clk,
  input logic            rst,
  rom_fetch_buf_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [DATA_WIDTH:0] entry_t;  // {last, data}

  entry_t          store_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            rd_pend_q, rd_pend_d;
  logic            last_pend_q, last_pend_d;

  logic            clear;
  logic            accept;
  logic            wr_en;
  logic            pop;
  logic [CntW-1:0] used;
  entry_t          head;

  // Entries committed or in flight; a same-cycle pop is deliberately not credited.
  assign used  = count_q + CntW'(rd_pend_q);
  assign clear = ~rst | bus.flush;

  assign bus.addr_ready = rst & ~bus.flush & (used < CntW'(DEPTH));
  assign accept         = bus.addr_valid & bus.addr_ready;
  assign bus.mem_rd_en  = accept;
  assign bus.mem_addr   = bus.addr_in;

  // A clear also drops the word returning for a read issued in the clear cycle's predecessor.
  assign wr_en = rd_pend_q & ~clear;
  assign pop   = bus.dout_valid & bus.dout_ready & ~clear;

  assign head           = store_q[rptr_q];
  assign bus.dout_valid = (count_q != '0);
  assign bus.dout       = head[DATA_WIDTH-1:0];
  assign bus.dout_last  = head[DATA_WIDTH] & bus.dout_valid;
  assign bus.occupancy  = count_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rd_pend_d   = accept;
    last_pend_d = bus.addr_last;
    if (clear) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      rd_pend_d = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PtrW'(1);
      if (pop)   rptr_d = rptr_q + PtrW'(1);
      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      last_pend_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rd_pend_q   <= rd_pend_d;
      last_pend_q <= last_pend_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (wr_en) store_q[wptr_q] <= {last_pend_q, bus.mem_rdata};
  end
endmodule

// File: tb/tb_rom_fetch_buf.sv
// Bench for rom_fetch_buf. A ROM model answers reads one cycle later; a reference queue holds
// every accepted {word, last, accept cycle} and is checked every cycle at the falling edge.
module tb_rom_fetch_buf;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;

  logic [DW-1:0] rom [256];
  exp_t          exp_q[$];

  rom_fetch_buf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  rom_fetch_buf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM; returns noise when not read so stray writes are visible.
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? rom[bus.mem_addr] : DW'($urandom);

  // Reference model: a word accepted in cycle N is visible from cycle N+2; room exists while
  // fewer than DEPTH words are accepted-but-unpopped.
  always @(negedge clk) begin
    if (mon_en) begin
      int      vis;
      logic    exp_ready;
      logic [OW-1:0] exp_occ;
      exp_t    e;
      vis = 0;
      foreach (exp_q[i]) if (exp_q[i].acc + 2 <= cyc) vis++;
      exp_occ   = OW'(vis);
      exp_ready = rst && !bus.flush && (exp_q.size() < DEPTH);
      checks++;
      if (bus.occupancy !== exp_occ) begin
        errors++; $display("FAIL mon_occupancy cyc=%0d got=%0d want=%0d", cyc, bus.occupancy, vis);
      end
      checks++;
      if (bus.dout_valid !== (vis != 0)) begin
        errors++; $display("FAIL mon_dout_valid cyc=%0d got=%b want=%b", cyc, bus.dout_valid, vis != 0);
      end
      if (vis != 0) begin
        checks++;
        if (bus.dout !== exp_q[0].data || bus.dout_last !== exp_q[0].last) begin
          errors++;
          $display("FAIL mon_dout cyc=%0d got=%h/%b want=%h/%b", cyc, bus.dout, bus.dout_last,
                   exp_q[0].data, exp_q[0].last);
        end
      end
      checks++;
      if (bus.addr_ready !== exp_ready) begin
        errors++; $display("FAIL mon_addr_ready cyc=%0d got=%b want=%b", cyc, bus.addr_ready, exp_ready);
      end
      checks++;
      if (bus.mem_rd_en !== (bus.addr_valid && exp_ready)) begin
        errors++;
        $display("FAIL mon_mem_rd_en cyc=%0d got=%b want=%b", cyc, bus.mem_rd_en,
                 bus.addr_valid && exp_ready);
      end
      if (bus.mem_rd_en === 1'b1) begin
        checks++;
        if (bus.mem_addr !== bus.addr_in) begin
          errors++; $display("FAIL mon_mem_addr got=%h want=%h", bus.mem_addr, bus.addr_in);
        end
      end
      if (!rst || bus.flush) begin
        exp_q.delete();
      end else begin
        if (vis != 0 && bus.dout_ready) begin
          pops++;
          void'(exp_q.pop_front());
        end
        if (bus.addr_valid && exp_ready) begin
          e.data = rom[bus.addr_in];
          e.last = bus.addr_last;
          e.acc  = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.addr_valid = 1'b1;
    bus.addr_in = 8'h03;
    @(negedge clk);
    checks++;
    if (bus.addr_ready !== 1'b0) begin errors++; $display("FAIL rst_addr_ready got=%b want=0", bus.addr_ready); end
    checks++;
    if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mem_rd_en got=%b want=0", bus.mem_rd_en); end
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout_last !== 1'b0 || bus.occupancy !== '0) begin
      errors++;
      $display("FAIL rst_outputs got=%b/%b/%0d want=0/0/0", bus.dout_valid, bus.dout_last, bus.occupancy);
    end
    tick();
    rst = 1'b1;
    bus.addr_valid = 1'b0;
  endtask

  task automatic test_single();
    rom[5] = 16'h1234;
    bus.dout_ready = 1'b0;
    bus.addr_in = 8'h05;
    bus.addr_valid = 1'b1;
    bus.addr_last = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.addr_ready !== 1'b1) begin errors++; $display("FAIL single_accept got=%b want=1", bus.addr_ready); end
    tick();
    bus.addr_valid = 1'b0;
    bus.addr_last = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b want=0", bus.dout_valid); end
    tick();
    bus.dout_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 16'h1234 || bus.dout_last !== 1'b1 ||
        bus.occupancy !== OW'(1)) begin
      errors++;
      $display("FAIL single_word got=%b/%h/%b/%0d want=1/1234/1/1", bus.dout_valid, bus.dout,
               bus.dout_last, bus.occupancy);
    end
    tick();
    bus.dout_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== '0 || bus.dout_valid !== 1'b0) begin
      errors++; $display("FAIL single_drained got=%0d/%b want=0/0", bus.occupancy, bus.dout_valid);
    end
    tick();
  endtask

  task automatic test_burst();
    for (int a = 0; a < 8; a++) rom[a] = DW'(a * 3);
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.addr_valid = (k < 8);
      bus.addr_in = AW'(k);
      bus.addr_last = (k == 7);
      @(negedge clk);
      if (k < 8) begin
        checks++;
        if (bus.addr_ready !== 1'b1) begin errors++; $display("FAIL burst_ready k=%0d got=%b want=1", k, bus.addr_ready); end
      end
      if (k >= 2) begin
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== DW'((k - 2) * 3) || bus.dout_last !== (k == 9)) begin
          errors++;
          $display("FAIL burst_beat k=%0d got=%b/%h/%b want=1/%h/%b", k, bus.dout_valid, bus.dout,
                   bus.dout_last, DW'((k - 2) * 3), k == 9);
        end
      end
      tick();
    end
    bus.addr_valid = 1'b0;
    bus.addr_last = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL burst_end got=%b want=0", bus.dout_valid); end
    tick();
    bus.dout_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int p0 = pops;
    for (int a = 0; a < 10; a++) rom[a] = DW'($urandom);
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.addr_valid = 1'b1;
      bus.addr_in = AW'(acc);
      bus.addr_last = (acc == 9);
      @(negedge clk);
      if (bus.addr_ready === 1'b1) acc++;
      tick();
    end
    @(negedge clk);
    checks++;
    if (acc != 4 || bus.addr_ready !== 1'b0 || bus.occupancy !== OW'(DEPTH)) begin
      errors++;
      $display("FAIL bp_stall got=%0d/%b/%0d want=4/0/4", acc, bus.addr_ready, bus.occupancy);
    end
    tick();
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.addr_valid = (acc < 10);
      bus.addr_in = AW'(acc);
      bus.addr_last = (acc == 9);
      @(negedge clk);
      if (bus.addr_valid && bus.addr_ready === 1'b1) acc++;
      tick();
    end
    bus.addr_valid = 1'b0;
    bus.addr_last = 1'b0;
    bus.dout_ready = 1'b0;
    checks++;
    if (acc != 10 || pops - p0 != 10) begin
      errors++; $display("FAIL bp_count got=%0d/%0d want=10/10", acc, pops - p0);
    end
  endtask

  task automatic test_flush();
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rom[16 + k] = DW'($urandom);
      bus.addr_valid = 1'b1;
      bus.addr_in = AW'(16 + k);
      bus.addr_last = (k == 3);
      @(negedge clk);
      tick();
    end
    bus.addr_valid = 1'b0;
    bus.addr_last = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== OW'(3) || bus.addr_ready !== 1'b0) begin
      errors++; $display("FAIL flush_cycle got=%0d/%b want=3/0", bus.occupancy, bus.addr_ready);
    end
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== '0 || bus.dout_valid !== 1'b0 || bus.addr_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_after got=%0d/%b/%b want=0/0/1", bus.occupancy, bus.dout_valid, bus.addr_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL flush_inflight got=%b want=0", bus.dout_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.addr_valid = (k < 2);
      bus.addr_in = AW'(32 + k);
      bus.addr_last = 1'b0;
      @(negedge clk);
      tick();
    end
    bus.addr_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== OW'(2) || bus.addr_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_cycle got=%0d/%b want=2/0", bus.occupancy, bus.addr_ready);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== '0 || bus.dout_valid !== 1'b0 || bus.dout_last !== 1'b0 ||
        bus.mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after got=%0d/%b/%b/%b want=0/0/0/0", bus.occupancy, bus.dout_valid,
               bus.dout_last, bus.mem_rd_en);
    end
    tick();
    test_single();
  endtask

  task automatic test_wrap();
    int acc = 0;
    int p0 = pops;
    foreach (rom[i]) rom[i] = DW'($urandom);
    for (int k = 0; k < 200; k++) begin
      bus.dout_ready = 1'($urandom_range(0, 1));
      bus.addr_valid = (acc < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
      bus.addr_in = AW'($urandom);
      bus.addr_last = (acc == 3 * DEPTH - 1);
      @(negedge clk);
      if (bus.addr_valid && bus.addr_ready === 1'b1) acc++;
      tick();
    end
    bus.addr_valid = 1'b0;
    bus.addr_last = 1'b0;
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    bus.dout_ready = 1'b0;
    checks++;
    if (acc != 3 * DEPTH || pops - p0 != 3 * DEPTH || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_count got=%0d/%0d/%0d want=%0d/%0d/0", acc, pops - p0, exp_q.size(),
               3 * DEPTH, 3 * DEPTH);
    end
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.addr_in = '0;
    bus.addr_valid = 1'b0;
    bus.addr_last = 1'b0;
    bus.dout_ready = 1'b0;
    foreach (rom[i]) rom[i] = DW'($urandom);
    tick();
    tick();
    mon_en = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
